imem_loader: RTL
================

Name: imem_loader

Overview:
- Write-side companion to the instruction memory: receives a program image as a byte stream with a valid/ready handshake and packs it into 32-bit big-endian words.
- Issues one write per word to the instruction memory write port, starting at START_ADDR and incrementing.
- Holds the CPU off (busy) while loading and reports completion or error.
- Sits between the boot/UART byte source and the instruction memory.

Parameters:
- MEM_SIZE, 128: number of 32-bit instruction words; highest writable index is MEM_SIZE-1.
- START_ADDR, 1: word index of the first instruction written (index 0 is reserved).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that opens a load session; ignored while busy.
- in_valid  in  1  byte source has data.
- in_data  in  8  image byte, most significant byte of each word first.
- in_last  in  1  marks the final image byte; sampled with in_data.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction memory write enable, single-cycle pulse.
- mem_addr  out  32  word index being written.
- mem_wdata  out  32  packed instruction word.
- busy  out  1  load session in progress; CPU must stay stalled.
- done  out  1  image loaded successfully; sticky until next start.
- err  out  1  load failed; sticky until next start.
- word_count  out  8  number of words written in the current or last session.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE immediately.
  - All outputs are 0: in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, word_count.
  - Byte index and the internal word register clear.
- IDLE:
  - in_ready=0.
  - start=1 goes to COLLECT next cycle; mem_addr<=START_ADDR, word_count<=0, byte index<=0, done<=0, err<=0, busy<=1.
- COLLECT:
  - in_ready=1.
  - A byte transfers only when in_valid & in_ready. On transfer: word <= {word[23:0], in_data}, byte index += 1.
  - Transfer at byte index 3 goes to WRITE next cycle; in_last is latched.
  - Transfer with in_last=1 at byte index 0..2 (partial word) goes to ERROR; no write occurs.
- WRITE (exactly one cycle):
  - in_ready=0, mem_we=1, mem_wdata=packed word, mem_addr=current index.
  - Next cycle: mem_addr+=1, word_count+=1, byte index<=0.
  - If the latched last flag is set, go to DONE (or CHECK when the optional feature is enabled).
  - Otherwise, if the index just written was MEM_SIZE-1, go to ERROR (overflow); else return to COLLECT.
- DONE: done=1, busy=0, in_ready=0. start opens a new session.
- ERROR: err=1, busy=0, in_ready=0. start opens a new session and clears err.
- Timing rules:
  - mem_we is asserted only in WRITE, at most once per 5 cycles.
  - Minimum throughput: 4 accepted bytes plus 1 write cycle per word.
  - mem_addr and mem_wdata hold their last values outside WRITE.
  - done and err are never both 1.
  - start while busy has no effect.
- Reset mid-word discards the partial word; no write is issued.

Optional Feature:
- Macro: IMEM_LOADER_CHKSUM_EN.
- Enabled:
  - The loader keeps a running XOR of every accepted image byte.
  - After the last WRITE it enters CHECK with in_ready=1 and accepts exactly one checksum byte; in_last is ignored for this byte.
  - Checksum equal to the running XOR goes to DONE; a mismatch goes to ERROR. Words already written stay written.
- Disabled: no CHECK state and no XOR register; the last WRITE goes directly to DONE.

Test Plan:
- Basic load: reset, pulse start, stream 12 34 56 78 9A BC DE F0 with in_last on the 8th byte. Required: writes addr 1=0x12345678 and addr 2=0x9ABCDEF0; done=1, busy=0, word_count=2.
- Gaps and stall: same stream with in_valid toggling every other cycle. Required: identical writes; in_ready=0 in each WRITE cycle; no byte lost or duplicated.
- Partial word: in_last on the 6th byte. Required: exactly one write (addr 1), then err=1, done=0, word_count=1.
- Overflow: 128 full words with no in_last. Required: writes at addr 1..127, err=1, word_count=127, no write at addr 128.
- Reset mid-word: assert rst_n=0 after 2 bytes of word 2. Required: all outputs 0 in the same cycle, no second write; a new start then loads correctly from addr 1.
- Checksum (macro defined): bytes 12 34 56 78 with last, then checksum 0x08. Required: done=1. Repeat with 0x09. Required: err=1, with 0x12345678 still written at addr 1.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream to instruction-memory loader: packs big-endian bytes into 32-bit words
// and writes them from START_ADDR upward. Define IMEM_LOADER_CHKSUM_EN to add a trailing XOR checksum byte.
module imem_loader #(
  parameter int MEM_SIZE   = 128,
  parameter int START_ADDR = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  word_count
);

`ifdef IMEM_LOADER_CHKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE, S_ERROR, S_CHECK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE, S_ERROR} state_t;
`endif

  state_t      state, state_n;
  logic [1:0]  byte_idx;
  logic [31:0] word;
  logic        last_q;
  logic        accept;
  logic        open_session;
  logic        at_top;
`ifdef IMEM_LOADER_CHKSUM_EN
  logic [7:0]  xsum;
`endif

  // Handshake: a byte moves on a rising edge only when in_valid and in_ready are both high.
  assign accept       = in_valid & in_ready;
  assign open_session = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERROR));
  assign at_top       = (mem_addr == 32'(MEM_SIZE - 1));

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    mem_we   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_n = S_COLLECT;
      end
      S_COLLECT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept) begin
          if (byte_idx == 2'd3) state_n = S_WRITE;
          else if (in_last)     state_n = S_ERROR;
        end
      end
      S_WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
        if (last_q) begin
`ifdef IMEM_LOADER_CHKSUM_EN
          state_n = S_CHECK;
`else
          state_n = S_DONE;
`endif
        end else if (at_top) begin
          state_n = S_ERROR;
        end else begin
          state_n = S_COLLECT;
        end
      end
`ifdef IMEM_LOADER_CHKSUM_EN
      S_CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept) state_n = (in_data == xsum) ? S_DONE : S_ERROR;
      end
`endif
      S_DONE: begin
        done = 1'b1;
        if (start) state_n = S_COLLECT;
      end
      S_ERROR: begin
        err = 1'b1;
        if (start) state_n = S_COLLECT;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // mem_wdata is captured on the fourth byte so it stays stable through and after WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx   <= 2'd0;
      word       <= 32'd0;
      last_q     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      word_count <= 8'd0;
`ifdef IMEM_LOADER_CHKSUM_EN
      xsum       <= 8'd0;
`endif
    end else if (open_session) begin
      byte_idx   <= 2'd0;
      last_q     <= 1'b0;
      mem_addr   <= 32'(START_ADDR);
      word_count <= 8'd0;
`ifdef IMEM_LOADER_CHKSUM_EN
      xsum       <= 8'd0;
`endif
    end else if (state == S_COLLECT && accept) begin
      word     <= {word[23:0], in_data};
      byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHKSUM_EN
      xsum     <= xsum ^ in_data;
`endif
      if (byte_idx == 2'd3) begin
        mem_wdata <= {word[23:0], in_data};
        last_q    <= in_last;
      end
    end else if (state == S_WRITE) begin
      mem_addr   <= mem_addr + 32'd1;
      word_count <= word_count + 8'd1;
      byte_idx   <= 2'd0;
    end
  end

endmodule
